data_mem_arbiter: RTL and testbench

Single-port arbiter that shares `data_mem` between the processor's load/store path and an external requester (debug/DMA) with a request/grant handshake. Sits between the processor datapath (`alu_result` address, `regD_data` write data, `load`/`store` decode) and the `data_mem` instance. It stalls the CPU through a stall output that the top level ANDs into `clock_enable`. Arbitration gives the CPU priority, bounds external waiting with an aging counter, and supports locked external bursts of bounded length.

---
 rtl/data_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Shares the single data_mem port between the CPU load/store path and an
// external requester. The CPU has priority, external waits are bounded by aging, and locked bursts are bounded by a beat count.
module data_mem_arbiter #(
  parameter int MAX_WAIT  = 3,
  parameter int MAX_BURST = 4
) (
  input  logic        clk_pi,
  input  logic        reset_pi,
  input  logic        clk_en_pi,
  input  logic        cpu_req_pi,
  input  logic        cpu_write_pi,
  input  logic [15:0] cpu_addr_pi,
  input  logic [15:0] cpu_wdata_pi,
  output logic [15:0] cpu_rdata_po,
  output logic        cpu_stall_po,
  input  logic        ext_req_pi,
  input  logic        ext_lock_pi,
  input  logic        ext_write_pi,
  input  logic [15:0] ext_addr_pi,
  input  logic [15:0] ext_wdata_pi,
  output logic        ext_gnt_po,
  output logic [15:0] ext_rdata_po,
  output logic        ext_rvalid_po,
  output logic        mem_write_po,
  output logic [15:0] mem_addr_po,
  output logic [15:0] mem_wdata_po,
  input  logic [15:0] mem_rdata_pi
);

  typedef enum logic {ARB, BURST} state_e;

  localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);
  localparam logic       BURST_OK  = (MAX_BURST > 1);

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic        cpu_turn_q, cpu_turn_d;
  logic [15:0] ext_rdata_q, ext_rdata_d;
  logic        ext_rvalid_q, ext_rvalid_d;

  logic        en;
  logic        aged;
  logic        ext_own;
  logic        cpu_gnt;
  logic        limit_exit;
  logic [3:0]  burst_inc;

  // Grant decision is purely combinational so the access happens in the
  // same cycle it is granted.
  always_comb begin
    en      = clk_en_pi & ~reset_pi;
    aged    = (wait_cnt_q == WAIT_MAX) & ~cpu_turn_q;
    ext_own = en & ext_req_pi & ((state_q == BURST) | ~cpu_req_pi | aged);
    cpu_gnt = en & cpu_req_pi & ~ext_own;
  end

  assign ext_gnt_po    = ext_own;
  assign cpu_stall_po  = en & cpu_req_pi & ext_own;
  assign cpu_rdata_po  = mem_rdata_pi;
  assign ext_rdata_po  = ext_rdata_q;
  assign ext_rvalid_po = ext_rvalid_q;

  always_comb begin
    mem_write_po = 1'b0;
    mem_addr_po  = '0;
    mem_wdata_po = '0;
    if (ext_own) begin
      mem_write_po = ext_write_pi;
      mem_addr_po  = ext_addr_pi;
      mem_wdata_po = ext_wdata_pi;
    end else if (en) begin
      mem_write_po = cpu_gnt & cpu_write_pi;
      mem_addr_po  = cpu_addr_pi;
      mem_wdata_po = cpu_wdata_pi;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    cpu_turn_d   = cpu_turn_q;
    ext_rdata_d  = ext_rdata_q;
    ext_rvalid_d = 1'b0;
    limit_exit   = 1'b0;
    burst_inc    = burst_cnt_q + 4'd1;

    if (ext_own && !ext_write_pi) begin
      ext_rdata_d  = mem_rdata_pi;
      ext_rvalid_d = 1'b1;
    end

    case (state_q)
      ARB: begin
        if (ext_own) begin
          wait_cnt_d = '0;
          if (ext_lock_pi && BURST_OK) begin
            state_d     = BURST;
            burst_cnt_d = 4'd1;
          end
        end else if (ext_req_pi) begin
          wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 4'd1;
        end else begin
          wait_cnt_d = '0;
        end
      end
      BURST: begin
        if (!ext_req_pi) begin
          state_d     = ARB;
          wait_cnt_d  = '0;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_inc;
          limit_exit  = (burst_inc >= BURST_MAX);
          if (!ext_lock_pi || limit_exit) begin
            state_d    = ARB;
            wait_cnt_d = '0;
          end
        end
      end
      default: state_d = ARB;
    endcase

    // A limit exit must still leave the CPU its guaranteed turn.
    if (cpu_gnt || !cpu_req_pi) cpu_turn_d = 1'b0;
    if (limit_exit)             cpu_turn_d = 1'b1;
  end

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state_q      <= ARB;
      wait_cnt_q   <= '0;
      burst_cnt_q  <= '0;
      cpu_turn_q   <= 1'b0;
      ext_rdata_q  <= '0;
      ext_rvalid_q <= 1'b0;
    end else if (clk_en_pi) begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      cpu_turn_q   <= cpu_turn_d;
      ext_rdata_q  <= ext_rdata_d;
      ext_rvalid_q <= ext_rvalid_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model of the arbitration rules.
module tb_data_mem_arbiter;
  localparam int MW = 3;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        reset, clk_en;
  logic        cpu_req, cpu_write;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ext_req, ext_lock, ext_write;
  logic [15:0] ext_addr, ext_wdata, ext_rdata;
  logic        ext_gnt, ext_rvalid;
  logic        mem_write;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.MAX_WAIT(MW), .MAX_BURST(MB)) dut (
    .clk_pi(clk), .reset_pi(reset), .clk_en_pi(clk_en),
    .cpu_req_pi(cpu_req), .cpu_write_pi(cpu_write), .cpu_addr_pi(cpu_addr),
    .cpu_wdata_pi(cpu_wdata), .cpu_rdata_po(cpu_rdata), .cpu_stall_po(cpu_stall),
    .ext_req_pi(ext_req), .ext_lock_pi(ext_lock), .ext_write_pi(ext_write),
    .ext_addr_pi(ext_addr), .ext_wdata_pi(ext_wdata), .ext_gnt_po(ext_gnt),
    .ext_rdata_po(ext_rdata), .ext_rvalid_po(ext_rvalid),
    .mem_write_po(mem_write), .mem_addr_po(mem_addr), .mem_wdata_po(mem_wdata),
    .mem_rdata_pi(mem_rdata)
  );

  // data_mem stand-in: combinational read, write at the rising edge
  logic [15:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;

  // Reference model: tracks "in a burst", beats taken, and how many times the
  // pending external request has lost to the CPU.
  logic [15:0] ref_mem [0:255];
  bit          m_burst, m_turn, m_rvalid;
  int          m_losses, m_beats;
  logic [15:0] m_rdata;
  bit          e_en, e_gnt, e_cpu, e_stall, e_mw;
  logic [15:0] e_ma, e_mwd;

  task automatic model_eval();
    e_en    = clk_en && !reset;
    e_gnt   = e_en && ext_req && (m_burst || !cpu_req || (m_losses == MW && !m_turn));
    e_cpu   = e_en && cpu_req && !e_gnt;
    e_stall = e_en && cpu_req && e_gnt;
    e_mw    = e_gnt ? ext_write : (e_cpu && cpu_write);
    e_ma    = e_gnt ? ext_addr  : (e_en ? cpu_addr  : 16'h0);
    e_mwd   = e_gnt ? ext_wdata : (e_en ? cpu_wdata : 16'h0);
  endtask

  task automatic model_commit();
    bit limit;
    limit = 0;
    if (reset) begin
      m_burst = 0; m_turn = 0; m_losses = 0; m_beats = 0;
      m_rvalid = 0; m_rdata = 16'h0;
    end else if (clk_en) begin
      if (e_gnt && !ext_write) begin
        m_rdata = ref_mem[ext_addr[7:0]]; m_rvalid = 1;
      end else m_rvalid = 0;
      if (e_mw) ref_mem[e_ma[7:0]] = e_mwd;
      if (!m_burst) begin
        if (e_gnt) begin
          m_losses = 0;
          if (ext_lock && MB > 1) begin m_burst = 1; m_beats = 1; end
        end else if (ext_req) m_losses = (m_losses < MW) ? m_losses + 1 : MW;
        else m_losses = 0;
      end else if (!ext_req) begin
        m_burst = 0; m_losses = 0;
      end else begin
        m_beats++;
        limit = (m_beats >= MB);
        if (!ext_lock || limit) begin m_burst = 0; m_losses = 0; end
      end
      if (e_cpu || !cpu_req) m_turn = 0;
      if (limit) m_turn = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    clk_en = 1; cpu_req = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_lock = 0; ext_write = 0; ext_addr = 0; ext_wdata = 0;
  endtask

  task automatic test_reset();
    reset = 1; clk_en = 1; cpu_req = 1; cpu_write = 1; ext_req = 1; ext_write = 1;
    cpu_addr = 16'h0011; ext_addr = 16'h0012;
    tick(); #3;
    checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got %b exp 0", ext_gnt); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", cpu_stall); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mwrite got %b exp 0", mem_write); end
    tick();
    reset = 0; idle_inputs(); #3;
    checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b exp 0", ext_rvalid); end
    checks++; if (ext_rdata !== 16'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0000", ext_rdata); end
    checks++; if ({ext_gnt, cpu_stall, mem_write} !== 3'b000) begin errors++; $display("FAIL idle_outs got %b exp 000", {ext_gnt, cpu_stall, mem_write}); end
    checks++; if (mem_addr !== 16'h0010 - 16'h0010) begin errors++; $display("FAIL idle_addr got %h exp 0000", mem_addr); end
  endtask

  task automatic test_cpu_store_load();
    tick();
    cpu_req = 1; cpu_write = 1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF; #3;
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL st_mwrite got %b exp 1", mem_write); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL st_stall got %b exp 0", cpu_stall); end
    checks++; if (mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL st_wdata got %h exp beef", mem_wdata); end
    tick();
    cpu_write = 0; cpu_wdata = 0; #3;
    checks++; if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL ld_rdata got %h exp beef", cpu_rdata); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL ld_mwrite got %b exp 0", mem_write); end
  endtask

  task automatic test_aging();
    tick();
    for (int c = 0; c < 5; c++) begin
      cpu_req = 1; cpu_write = 0; cpu_addr = 16'h0040;
      ext_req = (c <= 3); ext_write = 0; ext_addr = 16'h0010; #3;
      checks++; if (ext_gnt !== (c == 3)) begin errors++; $display("FAIL age_gnt c=%0d got %b exp %b", c, ext_gnt, c == 3); end
      checks++; if (cpu_stall !== (c == 3)) begin errors++; $display("FAIL age_stall c=%0d got %b exp %b", c, cpu_stall, c == 3); end
      if (c == 4) begin
        checks++; if (ext_rvalid !== 1'b1) begin errors++; $display("FAIL age_rvalid got %b exp 1", ext_rvalid); end
        checks++; if (ext_rdata !== 16'hBEEF) begin errors++; $display("FAIL age_rdata got %h exp beef", ext_rdata); end
      end
      tick();
    end
    idle_inputs(); tick();
  endtask

  task automatic test_burst();
    logic [15:0] a;
    bit exp;
    a = 16'h0020;
    for (int c = 0; c < 12; c++) begin
      cpu_req = 1; cpu_write = 0; cpu_addr = 16'h0040;
      ext_req = 1; ext_lock = 1; ext_write = 1; ext_addr = a; ext_wdata = 16'hA000 + a; #3;
      exp = (c >= 3 && c <= 6) || c >= 10;
      checks++; if (ext_gnt !== exp) begin errors++; $display("FAIL burst_gnt c=%0d got %b exp %b", c, ext_gnt, exp); end
      checks++; if (cpu_stall !== exp) begin errors++; $display("FAIL burst_stall c=%0d got %b exp %b", c, cpu_stall, exp); end
      if (ext_gnt) a++;
      tick();
    end
    idle_inputs(); tick();
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (mem[8'h20 + i] !== ((i < 6) ? 16'hA020 + 16'(i) : 16'h0)) begin
        errors++; $display("FAIL burst_mem i=%0d got %h", i, mem[8'h20 + i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    ext_req = 1; ext_lock = 1; ext_write = 1; ext_addr = 16'h0030; ext_wdata = 16'h1111; #3;
    checks++; if (ext_gnt !== 1'b1) begin errors++; $display("FAIL rb_beat1 got %b exp 1", ext_gnt); end
    tick();
    ext_addr = 16'h0031; ext_wdata = 16'h2222; reset = 1; #3;
    checks++; if ({ext_gnt, mem_write} !== 2'b00) begin errors++; $display("FAIL rb_beat2 got %b exp 00", {ext_gnt, mem_write}); end
    tick();
    reset = 0; cpu_req = 1; cpu_addr = 16'h0040; ext_write = 0; #3;
    checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL rb_rvalid got %b exp 0", ext_rvalid); end
    checks++; if (mem[8'h31] !== 16'h0) begin errors++; $display("FAIL rb_mem31 got %h exp 0000", mem[8'h31]); end
    checks++; if (mem[8'h30] !== 16'h1111) begin errors++; $display("FAIL rb_mem30 got %h exp 1111", mem[8'h30]); end
    checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL rb_arb got %b exp 0", ext_gnt); end
    tick(); idle_inputs(); tick();
  endtask

  task automatic test_clk_en();
    bit exp;
    for (int c = 0; c < 7; c++) begin
      clk_en = !(c >= 2 && c <= 4);
      cpu_req = 1; cpu_write = 1; cpu_addr = 16'h0050; cpu_wdata = 16'h5555;
      ext_req = 1; ext_lock = 0; ext_write = 0; ext_addr = 16'h0010; #3;
      exp = (c == 6);
      checks++; if (ext_gnt !== exp) begin errors++; $display("FAIL en_gnt c=%0d got %b exp %b", c, ext_gnt, exp); end
      checks++; if (cpu_stall !== exp) begin errors++; $display("FAIL en_stall c=%0d got %b exp %b", c, cpu_stall, exp); end
      checks++; if (mem_write !== (clk_en && !exp)) begin errors++; $display("FAIL en_mwrite c=%0d got %b exp %b", c, mem_write, clk_en && !exp); end
      tick();
    end
    idle_inputs(); #3;
    checks++; if ({ext_rvalid, ext_rdata} !== {1'b1, 16'hBEEF}) begin errors++; $display("FAIL en_read got %b/%h exp 1/beef", ext_rvalid, ext_rdata); end
    tick();
  endtask

  task automatic test_random();
    bit pend;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    reset = 1; idle_inputs(); tick();
    model_eval(); @(posedge clk); model_commit(); #1;
    reset = 0;
    pend = 0;
    for (int c = 0; c < 800; c++) begin
      reset  = ($urandom_range(0, 59) == 0);
      clk_en = ($urandom_range(0, 7) != 0);
      cpu_req = ($urandom_range(0, 3) != 0); cpu_write = 1'($urandom);
      cpu_addr = 16'h0080 | 16'($urandom_range(0, 127)); cpu_wdata = 16'($urandom);
      if (!pend) begin
        ext_req = ($urandom_range(0, 2) != 0); ext_lock = 1'($urandom); ext_write = 1'($urandom);
        ext_addr = 16'h0080 | 16'($urandom_range(0, 127)); ext_wdata = 16'($urandom);
      end
      model_eval(); #3;
      checks++; if (ext_gnt !== e_gnt) begin errors++; $display("FAIL rnd_gnt c=%0d got %b exp %b", c, ext_gnt, e_gnt); end
      checks++; if (cpu_stall !== e_stall) begin errors++; $display("FAIL rnd_stall c=%0d got %b exp %b", c, cpu_stall, e_stall); end
      checks++; if (mem_write !== e_mw) begin errors++; $display("FAIL rnd_mwrite c=%0d got %b exp %b", c, mem_write, e_mw); end
      checks++; if (mem_addr !== e_ma) begin errors++; $display("FAIL rnd_maddr c=%0d got %h exp %h", c, mem_addr, e_ma); end
      checks++; if (mem_wdata !== e_mwd) begin errors++; $display("FAIL rnd_mwdata c=%0d got %h exp %h", c, mem_wdata, e_mwd); end
      checks++; if (ext_rvalid !== m_rvalid) begin errors++; $display("FAIL rnd_rvalid c=%0d got %b exp %b", c, ext_rvalid, m_rvalid); end
      checks++; if (ext_rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata c=%0d got %h exp %h", c, ext_rdata, m_rdata); end
      if (e_cpu && !cpu_write) begin
        checks++; if (cpu_rdata !== ref_mem[cpu_addr[7:0]]) begin errors++; $display("FAIL rnd_cpu_rdata c=%0d got %h exp %h", c, cpu_rdata, ref_mem[cpu_addr[7:0]]); end
      end
      pend = ext_req && !e_gnt;
      @(posedge clk); model_commit(); #1;
    end
    reset = 0; idle_inputs(); tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    reset = 1; idle_inputs();
    test_reset();
    test_cpu_store_load();
    test_aging();
    test_burst();
    test_reset_mid_burst();
    test_clk_en();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
